// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for a register bank, with bank-clear sequencing.
// Optional burst lock enabled by defining REG_ARB_LOCK_EN.
module reg_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 16,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_W     = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          clear_all,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [DEPTH-1:0]              reg_clk_en,
    output logic [DEPTH-1:0]              reg_reset,
    output logic [WORD_WIDTH-1:0]         reg_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          addr_err
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_grant_ok;
    logic                  w_found;
    logic [IDW-1:0]        w_win;
    logic                  w_xfer;
    logic [ADDR_W-1:0]     w_addr;
    logic [WORD_WIDTH-1:0] w_data;
    logic                  w_in_range;
    logic [IDW-1:0]        r_ptr;
    logic [DEPTH-1:0]      r_clk_en;
    logic [WORD_WIDTH-1:0] r_data;
    logic [IDW-1:0]        r_grant;
    logic                  r_err;

`ifdef REG_ARB_LOCK_EN
    logic                  r_locked;
    logic [IDW-1:0]        r_lock_id;
    logic [3:0]            r_beats;
`else
    logic                  w_unused_lock;
    assign w_unused_lock = ^req_lock;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM next state: a clear request always enters CLEAR for one cycle
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (clear_all) w_next = S_CLEAR;
            S_CLEAR: w_next = clear_all ? S_CLEAR : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: bank reset during reset and CLEAR, grants only when idle
    always_comb begin
        reg_reset  = {DEPTH{reset | (r_state == S_CLEAR)}};
        w_grant_ok = (r_state == S_IDLE) && !clear_all && !stall;
    end

    // Winner search from the rotating pointer, or the lock holder
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(v_idx);
            end
        end
`ifdef REG_ARB_LOCK_EN
        if (r_locked) begin
            w_found = req_valid[r_lock_id];
            w_win   = r_lock_id;
        end
`endif
    end

    assign w_xfer     = w_grant_ok && w_found;
    assign req_ready  = w_xfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win) : '0;
    assign w_addr     = req_addr[w_win*ADDR_W +: ADDR_W];
    assign w_data     = req_data[w_win*WORD_WIDTH +: WORD_WIDTH];
    assign w_in_range = int'(w_addr) < DEPTH;

    // Issue the accepted write one cycle later and advance the pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_en <= '0;
            r_data   <= '0;
            r_grant  <= '0;
            r_err    <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_clk_en <= '0;
            if (w_xfer) begin
                r_grant <= w_win;
                r_data  <= w_data;
                r_ptr   <= (int'(w_win) == NUM_REQ-1) ? '0 : w_win + 1'b1;
                if (w_in_range)
                    r_clk_en <= {{(DEPTH-1){1'b0}}, 1'b1} << w_addr;
                else
                    r_err <= 1'b1;
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    // Burst lock: hold the grant until unlock request or beat limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_locked  <= 1'b0;
            r_lock_id <= '0;
            r_beats   <= '0;
        end else if (clear_all) begin
            r_locked <= 1'b0;
            r_beats  <= '0;
        end else if (w_xfer) begin
            if (r_locked) begin
                if (!req_lock[w_win] ||
                    ({1'b0, r_beats} + 5'd1 >= 5'(LOCK_MAX))) begin
                    r_locked <= 1'b0;
                    r_beats  <= '0;
                end else begin
                    r_beats <= r_beats + 4'd1;
                end
            end else if (req_lock[w_win] && LOCK_MAX > 1) begin
                r_locked  <= 1'b1;
                r_lock_id <= w_win;
                r_beats   <= 4'd1;
            end
        end
    end
`endif

    assign reg_clk_en = r_clk_en;
    assign reg_data   = r_data;
    assign grant_id   = r_grant;
    assign addr_err   = r_err;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed-vector bench for reg_write_arbiter (DEPTH=12 to exercise bad addresses).
// Lock scenario selected by REG_ARB_LOCK_EN.
module tb_reg_write_arbiter;
    localparam int N  = 4;
    localparam int D  = 12;
    localparam int W  = 32;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            clear_all;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_lock;
    logic [D-1:0]    reg_clk_en;
    logic [D-1:0]    reg_reset;
    logic [W-1:0]    reg_data;
    logic [1:0]      grant_id;
    logic            addr_err;

    int n_chk  = 0;
    int n_fail = 0;

    reg_write_arbiter #(
        .NUM_REQ(N), .DEPTH(D), .WORD_WIDTH(W), .ADDR_W(AW), .LOCK_MAX(8)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .clear_all(clear_all),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_lock(req_lock),
        .reg_clk_en(reg_clk_en), .reg_reset(reg_reset),
        .reg_data(reg_data), .grant_id(grant_id), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [W-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*W +: W]   = d;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; clear_all = 1'b0;
        req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0;
        #1;
        chk("rst_reg_reset", 64'(reg_reset), 64'hFFF);
        chk("rst_clk_en", 64'(reg_clk_en), 64'h0);
        chk("rst_data", 64'(reg_data), 64'h0);
        chk("rst_grant", 64'(grant_id), 64'h0);
        chk("rst_err", 64'(addr_err), 64'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_reg_reset", 64'(reg_reset), 64'h0);

        // Single write from requester 0
        set_req(0, 4'd3, 32'hDEADBEEF);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        chk("t1_clk_en", 64'(reg_clk_en), 64'h008);
        chk("t1_data", 64'(reg_data), 64'hDEADBEEF);
        chk("t1_grant", 64'(grant_id), 64'h0);

        // All requesting: rotation 1,2,3,0
        for (int i = 0; i < N; i++) set_req(i, AW'(4 + i), 32'h100 + i);
        req_valid = 4'b1111;
        for (int k = 0; k < N; k++) begin
            int w;
            w = (k + 1) % N;
            #1;
            chk("rr_ready", 64'(req_ready), 64'(1) << w);
            tick();
            chk("rr_clk_en", 64'(reg_clk_en), 64'(1) << (4 + w));
            chk("rr_grant", 64'(grant_id), 64'(w));
            chk("rr_data", 64'(reg_data), 64'h100 + 64'(w));
        end
        req_valid = '0;
        tick();
        chk("idle_clk_en", 64'(reg_clk_en), 64'h0);
        chk("idle_data_hold", 64'(reg_data), 64'h100);

        // Clear wins over a simultaneous request
        set_req(1, 4'd9, 32'hC1);
        req_valid = 4'b0010;
        clear_all = 1'b1;
        #1;
        chk("clr_ready0", 64'(req_ready), 64'h0);
        tick();
        clear_all = 1'b0;
        #1;
        chk("clr_reg_reset", 64'(reg_reset), 64'hFFF);
        chk("clr_ready1", 64'(req_ready), 64'h0);
        chk("clr_clk_en", 64'(reg_clk_en), 64'h0);
        tick();
        chk("clr_done", 64'(reg_reset), 64'h0);
        chk("clr_ready2", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        chk("clr_wr_clk_en", 64'(reg_clk_en), 64'h200);
        chk("clr_wr_grant", 64'(grant_id), 64'h1);

        // Out-of-range address from requester 2
        set_req(2, 4'd15, 32'hE2);
        req_valid = 4'b0100;
        #1;
        chk("oor_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        chk("oor_clk_en", 64'(reg_clk_en), 64'h0);
        chk("oor_err", 64'(addr_err), 64'h1);
        chk("oor_grant", 64'(grant_id), 64'h2);
        tick();
        chk("oor_err_sticky", 64'(addr_err), 64'h1);

        // Stall blocks grants; resume at requester 3
        for (int i = 0; i < N; i++) set_req(i, AW'(4 + i), 32'h200 + i);
        req_valid = 4'b1111;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 64'(req_ready), 64'h0);
            tick();
            chk("stall_clk_en", 64'(reg_clk_en), 64'h0);
        end
        stall = 1'b0;
        #1;
        chk("resume_ready", 64'(req_ready), 64'h8);
        tick();
        chk("resume_clk_en", 64'(reg_clk_en), 64'h080);
        chk("resume_grant", 64'(grant_id), 64'h3);

        // Requester 1 asks for a locked burst
        req_valid = 4'b1110;
        req_lock  = 4'b0010;
        #1;
        chk("lk_first", 64'(req_ready), 64'h2);
        tick();
`ifdef REG_ARB_LOCK_EN
        req_valid = 4'b1111;
        for (int k = 1; k < 8; k++) begin
            #1;
            chk("lk_hold", 64'(req_ready), 64'h2);
            tick();
            chk("lk_grant", 64'(grant_id), 64'h1);
        end
        #1;
        chk("lk_release", 64'(req_ready), 64'h4);
`else
        #1;
        chk("nolk_rot2", 64'(req_ready), 64'h4);
        tick();
        #1;
        chk("nolk_rot3", 64'(req_ready), 64'h8);
        tick();
        req_valid = 4'b1111;
        #1;
        chk("nolk_rot0", 64'(req_ready), 64'h1);
`endif
        req_lock = '0;
        chk("err_still_set", 64'(addr_err), 64'h1);

        // Reset lands right after an accept: the strobe is lost
        req_valid = 4'b0000;
        tick();
        set_req(0, 4'd2, 32'h55);
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = '0;
        reset = 1'b1;
        #1;
        chk("mid_rst_clk_en", 64'(reg_clk_en), 64'h0);
        chk("mid_rst_err", 64'(addr_err), 64'h0);
        chk("mid_rst_grant", 64'(grant_id), 64'h0);
        chk("mid_rst_reg_reset", 64'(reg_reset), 64'hFFF);
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the write port of a bank of DEPTH `register` instances between NUM_REQ requesters using round-robin arbitration.
- Each requester presents address and data on a valid/ready handshake.
- The winner's write is issued one cycle later as a one-hot clk_en strobe plus shared write data to the bank.
- Also sequences a bank-wide clear through the per-register reset inputs.
- Sits between the GEMM tile control logic and the accumulator/config register bank.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DEPTH, 16, number of registers in the bank
WORD_WIDTH, 32, register data width
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH
LOCK_MAX, 8, max consecutive beats a locked requester may hold the grant (only with REG_ARB_LOCK_EN)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  when high, no new grant is issued
clear_all  input  1  one-cycle pulse requesting a bank clear
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester accept, combinational, at most one bit high
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*WORD_WIDTH  packed data
req_lock  input  NUM_REQ  burst-lock request (used only with REG_ARB_LOCK_EN)
reg_clk_en  output  DEPTH  one-hot write strobe to the bank's clk_en inputs
reg_reset  output  DEPTH  per-register reset to the bank (all bits driven identically)
reg_data  output  WORD_WIDTH  shared write data to the bank's i_data inputs
grant_id  output  $clog2(NUM_REQ)  index of last accepted requester
addr_err  output  1  sticky flag: an out-of-range address was accepted

Behaviour:
- Reset (async assert, sync release): reg_clk_en=0, reg_reset=all 1s for the reset cycle then 0, reg_data=0, grant_id=0, addr_err=0.
  - Round-robin pointer resets so requester 0 has highest priority first.
  - FSM resets to IDLE.
- FSM states: IDLE, CLEAR.
  - IDLE: normal arbitration.
  - IDLE -> CLEAR when clear_all is sampled high.
  - In CLEAR, reg_reset is all 1s for exactly one cycle, then the FSM returns to IDLE.
  - No req_ready is asserted in CLEAR or in the cycle clear_all is high; clear wins over any simultaneous request.
- Arbitration, IDLE only, stall low:
  - The winner is the first requester with req_valid high, searching from (grant_id+1) mod NUM_REQ upward with wrap-around.
  - req_ready[winner]=1; all other ready bits are 0.
  - No valid requester -> no ready.
  - stall high -> req_ready=0.
- Transfer occurs when req_valid[i] && req_ready[i].
  - Next cycle: reg_clk_en has bit addr set for exactly one cycle, reg_data=that data, grant_id=i.
  - Latency: 1 cycle from accept to strobe. Throughput: 1 write per cycle.
- Out-of-range address (addr >= DEPTH):
  - Transfer still completes (ready high); reg_clk_en stays 0 and addr_err sets.
  - addr_err clears only on reset.
- reg_data holds its last value when no write occurs; reg_clk_en is 0 on every non-write cycle.
- Requesters may drop req_valid without a transfer; there is no hold requirement on the arbiter.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately.
  - A pending accepted write is lost.

Optional Feature:
REG_ARB_LOCK_EN
- Defined:
  - If the winner transfers with req_lock[i]=1, the grant is held for requester i on subsequent cycles, with no rotation.
  - The hold lasts until it transfers with req_lock[i]=0 or LOCK_MAX beats have transferred in the lock.
  - On forced release, the pointer rotates normally.
  - A 4-bit lock beat counter resets to 0 on release.
  - While locked and req_valid[i]=0, no other requester is granted.
  - clear_all still preempts and releases the lock.
- Not defined: req_lock is ignored; pure round-robin.

Test Plan:
- Reset, then req_valid=4'b0001, addr=3, data=0xDEADBEEF -> req_ready=0001 same cycle; next cycle reg_clk_en=16'h0008, reg_data=0xDEADBEEF, grant_id=0.
- req_valid=4'b1111 held for 4 cycles, each with distinct addresses -> grants in order 1,2,3,0 (pointer starts after 0 following the first test); one strobe per cycle.
- clear_all pulse concurrent with req_valid=4'b0010 -> no ready that cycle; next cycle reg_reset=all 1s; requester 1 accepted the following cycle.
- Requester 2 writes addr=15 with DEPTH=12 -> ready=1, no reg_clk_en bit set, addr_err=1 and stays 1 until reset.
- stall=1 with req_valid=4'b1111 for 3 cycles -> req_ready=0, reg_clk_en=0; stall=0 -> grant resumes at the next round-robin position.
- With REG_ARB_LOCK_EN, LOCK_MAX=8: requester 1 holds lock=1 and valid=1 while others are valid -> 8 consecutive grants to 1, then grant moves to 2.
